// File: rtl/alias_pkg.sv
// Shared definitions for the alias-reduction stage.
// Holds the Q1.17 butterfly coefficients, the sample/accumulator formats,
// the controller state encoding and the round-and-saturate helper used by
// every butterfly instance.
package alias_pkg;

  localparam int unsigned FRAC      = 17;
  localparam int unsigned SAMPLE_W  = 18;
  localparam int unsigned ACC_W     = 37;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned SB_LEN    = 18;
  localparam int unsigned NUM_BFLY  = 8;
  localparam int unsigned LAST_B    = 30;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CALC,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  // round(x * 2^17) of cs = 1/sqrt(1+c^2) and ca = c/sqrt(1+c^2)
  localparam sample_t CS [NUM_BFLY] = '{
    18'sd112393, 18'sd115572, 18'sd124470, 18'sd128885,
    18'sd130485, 18'sd130962, 18'sd131059, 18'sd131071
  };
  localparam sample_t CA [NUM_BFLY] = '{
    -18'sd67436, -18'sd61831, -18'sd41075, -18'sd23844,
    -18'sd12396, -18'sd5369,  -18'sd1861,  -18'sd485
  };

  localparam acc_t ROUND_HALF = acc_t'(1) <<< (FRAC - 1);
  localparam acc_t SAT_MAX    = acc_t'((1 << (SAMPLE_W - 1)) - 1);
  localparam acc_t SAT_MIN    = -acc_t'(1 << (SAMPLE_W - 1));

  // Round half up, drop the fraction, clamp to the sample range.
  function automatic sample_t round_sat(input acc_t acc);
    acc_t rounded;
    rounded = (acc + ROUND_HALF) >>> FRAC;
    if (rounded > SAT_MAX) begin
      return sample_t'(SAT_MAX);
    end
    if (rounded < SAT_MIN) begin
      return sample_t'(SAT_MIN);
    end
    return sample_t'(rounded);
  endfunction

endpackage

// File: rtl/alias_butterfly.sv
// One alias-reduction butterfly for a single channel (combinational).
//   lo, hi         : input samples (signed 18 bit)
//   cs, ca         : Q1.17 coefficients for the current butterfly index
//   lo_out, hi_out : rounded, saturated results
//     lo_out = lo*cs - hi*ca,  hi_out = hi*cs + lo*ca
module alias_butterfly
  import alias_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] lo,
  input  logic signed [SAMPLE_W-1:0] hi,
  input  logic signed [SAMPLE_W-1:0] cs,
  input  logic signed [SAMPLE_W-1:0] ca,
  output logic signed [SAMPLE_W-1:0] lo_out,
  output logic signed [SAMPLE_W-1:0] hi_out
);

  acc_t lo_acc;
  acc_t hi_acc;

  always_comb begin
    lo_acc = acc_t'(lo) * acc_t'(cs) - acc_t'(hi) * acc_t'(ca);
    hi_acc = acc_t'(hi) * acc_t'(cs) + acc_t'(lo) * acc_t'(ca);
    lo_out = round_sat(lo_acc);
    hi_out = round_sat(hi_acc);
  end

endmodule

// File: rtl/alias_reduction.sv
// Alias-reduction stage for two channels sharing one sequencer.
// Walks the 31 subband boundaries x 8 butterflies, reading the lo/hi pair
// from each channel's granule RAM, applying the butterfly and writing the
// pair back in place. Block-type flags only gate the write strobes, so the
// address sequence and run time are identical for every granule.
//   clk, rst                     : clock, async active-high reset
//   granule_chX_read_addr/data   : RAM read port (data one cycle after addr)
//   granule_chX_write_*          : RAM write port
//   chX_block_short/mixed        : block flags, latched on accepted start
//   stage_ready / stage_done     : start request / one-cycle completion pulse
module alias_reduction
  import alias_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_W-1:0]          granule_ch0_read_addr,
  input  logic signed [SAMPLE_W-1:0] granule_ch0_read_data,
  output logic                       granule_ch0_write_enable,
  output logic [ADDR_W-1:0]          granule_ch0_write_addr,
  output logic signed [SAMPLE_W-1:0] granule_ch0_write_data,
  output logic [ADDR_W-1:0]          granule_ch1_read_addr,
  input  logic signed [SAMPLE_W-1:0] granule_ch1_read_data,
  output logic                       granule_ch1_write_enable,
  output logic [ADDR_W-1:0]          granule_ch1_write_addr,
  output logic signed [SAMPLE_W-1:0] granule_ch1_write_data,
  input  logic                       ch0_block_short,
  input  logic                       ch0_block_mixed,
  input  logic                       ch1_block_short,
  input  logic                       ch1_block_mixed,
  input  logic                       stage_ready,
  output logic                       stage_done
);

  state_t state, state_next;

  logic [4:0] b_q;
  logic [2:0] i_q;
  logic [1:0] short_q;
  logic [1:0] mixed_q;

  sample_t rd_data  [2];
  sample_t lo_q     [2];
  sample_t res_lo_q [2];
  sample_t res_hi_q [2];
  sample_t bf_lo    [2];
  sample_t bf_hi    [2];
  sample_t wr_data  [2];
  sample_t cs_sel;
  sample_t ca_sel;

  logic [ADDR_W-1:0] lo_addr;
  logic [ADDR_W-1:0] hi_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        eligible;
  logic [1:0]        wr_en;
  logic              last_bfly;
  logic              done;

  assign rd_data[0] = granule_ch0_read_data;
  assign rd_data[1] = granule_ch1_read_data;
  assign cs_sel     = CS[i_q];
  assign ca_sel     = CA[i_q];

  // The hi sample is consumed straight off the read port in CALC.
  for (genvar ch = 0; ch < 2; ch++) begin : g_bfly
    alias_butterfly u_bfly (
      .lo     (lo_q[ch]),
      .hi     (rd_data[ch]),
      .cs     (cs_sel),
      .ca     (ca_sel),
      .lo_out (bf_lo[ch]),
      .hi_out (bf_hi[ch])
    );
  end

  always_comb begin
    lo_addr   = ADDR_W'(b_q) * ADDR_W'(SB_LEN) + ADDR_W'(SB_LEN - 1) - ADDR_W'(i_q);
    hi_addr   = ADDR_W'(b_q) * ADDR_W'(SB_LEN) + ADDR_W'(SB_LEN) + ADDR_W'(i_q);
    last_bfly = (b_q == 5'(LAST_B)) && (i_q == 3'(NUM_BFLY - 1));
    // Mixed blocks only alias-reduce the first boundary, regardless of short.
    for (int unsigned ch = 0; ch < 2; ch++) begin
      eligible[ch] = mixed_q[ch] ? (b_q == '0) : !short_q[ch];
    end
  end

  always_comb begin
    state_next = state;
    rd_addr    = '0;
    wr_addr    = '0;
    wr_en      = '0;
    done       = 1'b0;
    wr_data[0] = '0;
    wr_data[1] = '0;
    unique case (state)
      IDLE:  if (stage_ready) state_next = RD_LO;
      RD_LO: begin
        rd_addr    = lo_addr;
        state_next = RD_HI;
      end
      RD_HI: begin
        rd_addr    = hi_addr;
        state_next = CALC;
      end
      CALC:  state_next = WR_LO;
      WR_LO: begin
        wr_addr    = lo_addr;
        wr_en      = eligible;
        wr_data[0] = res_lo_q[0];
        wr_data[1] = res_lo_q[1];
        state_next = WR_HI;
      end
      WR_HI: begin
        wr_addr    = hi_addr;
        wr_en      = eligible;
        wr_data[0] = res_hi_q[0];
        wr_data[1] = res_hi_q[1];
        state_next = last_bfly ? DONE : RD_LO;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      b_q     <= '0;
      i_q     <= '0;
      short_q <= '0;
      mixed_q <= '0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        lo_q[ch]     <= '0;
        res_lo_q[ch] <= '0;
        res_hi_q[ch] <= '0;
      end
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (stage_ready) begin
            b_q     <= '0;
            i_q     <= '0;
            short_q <= {ch1_block_short, ch0_block_short};
            mixed_q <= {ch1_block_mixed, ch0_block_mixed};
          end
        end
        RD_HI: begin
          for (int unsigned ch = 0; ch < 2; ch++) begin
            lo_q[ch] <= rd_data[ch];
          end
        end
        CALC: begin
          for (int unsigned ch = 0; ch < 2; ch++) begin
            res_lo_q[ch] <= bf_lo[ch];
            res_hi_q[ch] <= bf_hi[ch];
          end
        end
        WR_HI: begin
          if (i_q == 3'(NUM_BFLY - 1)) begin
            i_q <= '0;
            if (!last_bfly) b_q <= b_q + 1'b1;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign granule_ch0_read_addr    = rd_addr;
  assign granule_ch1_read_addr    = rd_addr;
  assign granule_ch0_write_addr   = wr_addr;
  assign granule_ch1_write_addr   = wr_addr;
  assign granule_ch0_write_enable = wr_en[0];
  assign granule_ch1_write_enable = wr_en[1];
  assign granule_ch0_write_data   = wr_data[0];
  assign granule_ch1_write_data   = wr_data[1];
  assign stage_done               = done;

endmodule
